rv_program_loader: RTL and testbench

Instruction encoder and instruction-memory writer: the encode-side counterpart of the core's control decoder.
- Accepts symbolic instructions: kind, register fields and immediate.
- Packs them into RV32I machine words using the same six opcodes the core decodes: R-type add/sub, addi, lw, sw, beq, lui.
- Writes the words sequentially into instruction memory through a registered write port.
- Sits between the testbench or boot host and imem, so programs can be loaded without hand-assembled hex.

---
 rtl/rv_enc_pkg.sv | 35 +++
 rtl/rv_program_loader_if.sv | 26 ++
 rtl/rv_instr_encoder.sv | 51 +++++
 rtl/rv_program_loader.sv | 107 ++++++++++
 tb/tb_rv_program_loader.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_enc_pkg.sv
// rtl/rv_enc_pkg.sv - RV32I opcode/funct constants, instruction kinds and loader states
package rv_enc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  typedef enum logic [2:0] {
    KIND_ADD  = 3'd0,
    KIND_SUB  = 3'd1,
    KIND_ADDI = 3'd2,
    KIND_LW   = 3'd3,
    KIND_SW   = 3'd4,
    KIND_BEQ  = 3'd5,
    KIND_LUI  = 3'd6
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rv_program_loader_if.sv
// rtl/rv_program_loader_if.sv - instruction input handshake and imem write port bundle
interface rv_program_loader_if #(parameter int ADDR_W = 8);

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_imm, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_imm, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/rv_instr_encoder.sv
// rtl/rv_instr_encoder.sv - combinational packer of symbolic fields into an RV32I word
module rv_instr_encoder
  import rv_enc_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        imm_err,
  output logic        kind_err
);

  logic fits12;
  logic fits_br;

  always_comb begin
    fits12   = ($signed(imm) >= -32'sd2048) && ($signed(imm) <= 32'sd2047);
    fits_br  = ($signed(imm) >= -32'sd4096) && ($signed(imm) <= 32'sd4094) && !imm[0];
    word     = '0;
    imm_err  = 1'b0;
    kind_err = 1'b0;
    case (kind_e'(kind))
      KIND_ADD:  word = {F7_ADD, rs2, rs1, F3_ADD, rd, OP_R};
      KIND_SUB:  word = {F7_SUB, rs2, rs1, F3_ADD, rd, OP_R};
      KIND_ADDI: begin
        word    = {imm[11:0], rs1, F3_ADD, rd, OP_IMM};
        imm_err = !fits12;
      end
      KIND_LW: begin
        word    = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
        imm_err = !fits12;
      end
      KIND_SW: begin
        word    = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
        imm_err = !fits12;
      end
      KIND_BEQ: begin
        word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
        imm_err = !fits_br;
      end
      KIND_LUI: begin
        word    = {imm[31:12], rd, OP_LUI};
        imm_err = (imm[11:0] != 12'd0);
      end
      default:   kind_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_program_loader.sv
// rtl/rv_program_loader.sv - session FSM writing encoded instructions sequentially into imem
module rv_program_loader
  import rv_enc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  rv_program_loader_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_imm,
  output logic              err_kind,
  output logic              err_full
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       enc_word;
  logic              enc_imm_err;
  logic              enc_kind_err;
  logic              accept;
  logic              good;
  logic              full_hit;

  rv_instr_encoder u_enc (
    .kind     (bus.in_kind),
    .rd       (bus.in_rd),
    .rs1      (bus.in_rs1),
    .rs2      (bus.in_rs2),
    .imm      (bus.in_imm),
    .word     (enc_word),
    .imm_err  (enc_imm_err),
    .kind_err (enc_kind_err)
  );

  assign accept   = bus.in_valid && bus.in_ready;
  assign good     = !enc_imm_err && !enc_kind_err;
  assign full_hit = good && (ptr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      ptr            <= '0;
      count          <= '0;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_imm        <= 1'b0;
      err_kind       <= 1'b0;
      err_full       <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      done        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_LOAD;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
            ptr          <= '0;
            count        <= '0;
            err_imm      <= 1'b0;
            err_kind     <= 1'b0;
            err_full     <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            // Rejected instructions only raise a flag; the session keeps going.
            if (enc_kind_err) begin
              err_kind <= 1'b1;
            end else if (enc_imm_err) begin
              err_imm <= 1'b1;
            end else begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= ptr;
              bus.imem_wdata <= enc_word;
              ptr            <= ptr + 1'b1;
              count          <= count + 1'b1;
            end
            if (bus.in_last || full_hit) begin
              state        <= ST_DONE;
              bus.in_ready <= 1'b0;
              done         <= 1'b1;
            end
            if (full_hit && !bus.in_last) err_full <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_program_loader.sv
// tb/tb_rv_program_loader.sv - vector table, directed corners and randomized sessions vs a reference encoder
module tb_rv_program_loader;

  localparam int ADDR_W = 8;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    bit          last;
  } instr_t;

  typedef struct {
    instr_t      ins;
    bit          wr;
    logic [31:0] word;
    bit          e_imm;
    bit          e_kind;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  logic busy_a, done_a, err_imm_a, err_kind_a, err_full_a;
  logic busy_b, done_b, err_imm_b, err_kind_b, err_full_b;
  logic [ADDR_W:0] count_a, count_b;

  rv_program_loader_if #(.ADDR_W(ADDR_W)) ifa ();
  rv_program_loader_if #(.ADDR_W(ADDR_W)) ifb ();

  rv_program_loader #(.ADDR_W(ADDR_W), .DEPTH(256)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bus(ifa),
    .busy(busy_a), .done(done_a), .count(count_a),
    .err_imm(err_imm_a), .err_kind(err_kind_a), .err_full(err_full_a)
  );

  rv_program_loader #(.ADDR_W(ADDR_W), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bus(ifb),
    .busy(busy_b), .done(done_b), .count(count_b),
    .err_imm(err_imm_b), .err_kind(err_kind_b), .err_full(err_full_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [39:0] wr_a[$];
  logic [39:0] wr_b[$];
  int   done_a_n, done_b_n;
  bit   done_a_we;

  always @(negedge clk) begin
    if (ifa.imem_we) wr_a.push_back({ifa.imem_addr, ifa.imem_wdata});
    if (ifb.imem_we) wr_b.push_back({ifb.imem_addr, ifb.imem_wdata});
    if (done_a) begin
      done_a_n++;
      done_a_we = ifa.imem_we;
    end
    if (done_b) done_b_n++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference encoder: field placement by shift-and-mask arithmetic on the ISA layout.
  function automatic void model_enc(input instr_t i, output logic [31:0] w,
                                    output bit bad_imm, output bit bad_kind);
    logic [31:0] d, a, b, m;
    int s;
    d = 32'(i.rd); a = 32'(i.rs1); b = 32'(i.rs2); m = i.imm; s = $signed(i.imm);
    w = 32'h0; bad_imm = 1'b0; bad_kind = 1'b0;
    case (i.kind)
      3'd0: w = (b << 20) | (a << 15) | (d << 7) | 32'h33;
      3'd1: w = 32'h4000_0000 | (b << 20) | (a << 15) | (d << 7) | 32'h33;
      3'd2: begin w = ((m & 32'hFFF) << 20) | (a << 15) | (d << 7) | 32'h13; bad_imm = s < -2048 || s > 2047; end
      3'd3: begin w = ((m & 32'hFFF) << 20) | (a << 15) | (32'd2 << 12) | (d << 7) | 32'h03; bad_imm = s < -2048 || s > 2047; end
      3'd4: begin
        w = (((m >> 5) & 32'h7F) << 25) | (b << 20) | (a << 15) | (32'd2 << 12) | ((m & 32'h1F) << 7) | 32'h23;
        bad_imm = s < -2048 || s > 2047;
      end
      3'd5: begin
        w = (((m >> 12) & 32'h1) << 31) | (((m >> 5) & 32'h3F) << 25) | (b << 20) | (a << 15)
          | (((m >> 1) & 32'hF) << 8) | (((m >> 11) & 32'h1) << 7) | 32'h63;
        bad_imm = s < -4096 || s > 4094 || (s % 2 != 0);
      end
      3'd6: begin w = (m & 32'hFFFF_F000) | (d << 7) | 32'h37; bad_imm = (m & 32'hFFF) != 0; end
      default: bad_kind = 1'b1;
    endcase
  endfunction

  task automatic drive_a(input instr_t i);
    ifa.in_valid = 1'b1; ifa.in_kind = i.kind; ifa.in_rd = i.rd; ifa.in_rs1 = i.rs1;
    ifa.in_rs2 = i.rs2; ifa.in_imm = i.imm; ifa.in_last = i.last;
    @(posedge clk); #1;
    ifa.in_valid = 1'b0; ifa.in_last = 1'b0;
  endtask

  task automatic open_a(input string tag);
    int k;
    wr_a.delete(); done_a_n = 0; done_a_we = 1'b0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (k = 0; k < 8 && !ifa.in_ready; k++) begin @(posedge clk); #1; end
    chk({tag, " in_ready_after_start"}, 64'(ifa.in_ready), 64'd1);
  endtask

  task automatic close_a(input string tag, input logic [39:0] exp[$], input bit eimm,
                         input bit ekind, input bit edone_we);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, " nwrites"}, 64'(wr_a.size()), 64'(exp.size()));
    for (int k = 0; k < exp.size() && k < wr_a.size(); k++)
      chk($sformatf("%s write%0d", tag, k), 64'(wr_a[k]), 64'(exp[k]));
    chk({tag, " done_pulses"}, 64'(done_a_n), 64'd1);
    chk({tag, " done_with_we"}, 64'(done_a_we), 64'(edone_we));
    chk({tag, " count"}, 64'(count_a), 64'(exp.size()));
    chk({tag, " err_imm"}, 64'(err_imm_a), 64'(eimm));
    chk({tag, " err_kind"}, 64'(err_kind_a), 64'(ekind));
    chk({tag, " err_full"}, 64'(err_full_a), 64'd0);
    chk({tag, " busy_idle"}, 64'(busy_a), 64'd0);
  endtask

  function automatic instr_t mk(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [31:0] imm, input bit last);
    instr_t i;
    i.kind = k; i.rd = rd; i.rs1 = r1; i.rs2 = r2; i.imm = imm; i.last = last;
    return i;
  endfunction

  function automatic vec_t mv(input instr_t i, input bit wr, input logic [31:0] w,
                              input bit ei, input bit ek);
    vec_t v;
    v.ins = i; v.wr = wr; v.word = w; v.e_imm = ei; v.e_kind = ek;
    return v;
  endfunction

  initial begin
    vec_t        tab[$];
    logic [39:0] exp[$];
    logic [7:0]  ptr;
    logic [31:0] w;
    bit          bi, bk, any_i, any_k, last_good;
    instr_t      ins;
    bit          in_session;

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_kind = '0; ifa.in_rd = '0; ifa.in_rs1 = '0;
    ifa.in_rs2 = '0; ifa.in_imm = '0; ifa.in_last = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_kind = '0; ifb.in_rd = '0; ifb.in_rs1 = '0;
    ifb.in_rs2 = '0; ifb.in_imm = '0; ifb.in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset in_ready", 64'(ifa.in_ready), 64'd0);
    chk("reset imem_we", 64'(ifa.imem_we), 64'd0);
    chk("reset imem_addr", 64'(ifa.imem_addr), 64'd0);
    chk("reset imem_wdata", 64'(ifa.imem_wdata), 64'd0);
    chk("reset busy/done", 64'({busy_a, done_a}), 64'd0);
    chk("reset count", 64'(count_a), 64'd0);
    chk("reset errs", 64'({err_imm_a, err_kind_a, err_full_a}), 64'd0);

    // Table of sessions: a row with last=1 closes its session.
    tab.push_back(mv(mk(3'd2, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0), 1'b1, 32'h0050_0093, 1'b0, 1'b0));
    tab.push_back(mv(mk(3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0), 1'b1, 32'h0020_81B3, 1'b0, 1'b0));
    tab.push_back(mv(mk(3'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1), 1'b1, 32'h4020_81B3, 1'b0, 1'b0));
    tab.push_back(mv(mk(3'd3, 5'd5, 5'd2, 5'd0, 32'd8, 1'b0), 1'b1, 32'h0081_2283, 1'b0, 1'b0));
    tab.push_back(mv(mk(3'd4, 5'd0, 5'd2, 5'd5, 32'd12, 1'b0), 1'b1, 32'h0051_2623, 1'b0, 1'b0));
    tab.push_back(mv(mk(3'd5, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0), 1'b1, 32'hFE20_8EE3, 1'b0, 1'b0));
    tab.push_back(mv(mk(3'd6, 5'd7, 5'd0, 5'd0, 32'h1234_5000, 1'b1), 1'b1, 32'h1234_53B7, 1'b0, 1'b0));
    tab.push_back(mv(mk(3'd2, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0), 1'b0, 32'h0, 1'b1, 1'b0));
    tab.push_back(mv(mk(3'd5, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0), 1'b0, 32'h0, 1'b1, 1'b0));
    tab.push_back(mv(mk(3'd7, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0), 1'b0, 32'h0, 1'b1, 1'b1));
    tab.push_back(mv(mk(3'd2, 5'd0, 5'd0, 5'd0, 32'hFFFF_F800, 1'b1), 1'b1, 32'h8000_0013, 1'b1, 1'b1));

    in_session = 1'b0;
    ptr = '0;
    exp.delete();
    for (int r = 0; r < tab.size(); r++) begin
      if (!in_session) begin
        open_a($sformatf("tab%0d", r));
        in_session = 1'b1; ptr = '0; exp.delete();
      end
      drive_a(tab[r].ins);
      if (tab[r].wr) begin exp.push_back({ptr, tab[r].word}); ptr++; end
      if (tab[r].ins.last) begin
        close_a($sformatf("tab%0d", r), exp, tab[r].e_imm, tab[r].e_kind, tab[r].wr);
        in_session = 1'b0;
      end
    end

    // Gap in in_valid mid-session, with a stray start that must be ignored.
    open_a("gap");
    exp.delete();
    ins = mk(3'd2, 5'd4, 5'd4, 5'd0, 32'd100, 1'b0);
    model_enc(ins, w, bi, bk); exp.push_back({8'd0, w});
    drive_a(ins);
    @(posedge clk); #1;
    start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
    @(posedge clk); #1;
    chk("gap no writes", 64'(wr_a.size()), 64'd1);
    ins = mk(3'd0, 5'd6, 5'd4, 5'd5, 32'd0, 1'b1);
    model_enc(ins, w, bi, bk); exp.push_back({8'd1, w});
    drive_a(ins);
    close_a("gap", exp, 1'b0, 1'b0, 1'b1);

    // Randomized sessions against the reference encoder.
    for (int s = 0; s < 4; s++) begin
      open_a($sformatf("rnd%0d", s));
      exp.delete(); ptr = '0; any_i = 0; any_k = 0; last_good = 0;
      for (int n = 0; n < 30; n++) begin
        ins.kind = 3'($urandom_range(0, 7));
        ins.rd = 5'($urandom); ins.rs1 = 5'($urandom); ins.rs2 = 5'($urandom);
        case ($urandom_range(0, 3))
          0: ins.imm = 32'($signed($urandom_range(0, 4095)) - 2048);
          1: ins.imm = $urandom;
          2: ins.imm = 32'(($signed($urandom_range(0, 4095)) - 2048) * 2);
          default: ins.imm = $urandom & 32'hFFFF_F000;
        endcase
        ins.last = (n == 29);
        model_enc(ins, w, bi, bk);
        last_good = !bi && !bk;
        if (last_good) begin exp.push_back({ptr, w}); ptr++; end
        any_i |= bi; any_k |= bk;
        drive_a(ins);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #0;
      end
      close_a($sformatf("rnd%0d", s), exp, any_i, any_k, last_good);
    end

    // DEPTH=4 instance: memory fills before in_last.
    wr_b.delete(); done_b_n = 0;
    start_b = 1'b1; @(posedge clk); #1; start_b = 1'b0;
    exp.delete();
    for (int k = 0; k < 6; k++) begin
      ins = mk(3'd2, 5'(k + 1), 5'd0, 5'd0, 32'(k * 3), 1'b0);
      if (k < 4) begin model_enc(ins, w, bi, bk); exp.push_back({8'(k), w}); end
      ifb.in_valid = 1'b1; ifb.in_kind = ins.kind; ifb.in_rd = ins.rd; ifb.in_rs1 = ins.rs1;
      ifb.in_rs2 = ins.rs2; ifb.in_imm = ins.imm; ifb.in_last = 1'b0;
      @(posedge clk); #1;
      if (k == 3) chk("full in_ready drop", 64'(ifb.in_ready), 64'd0);
    end
    ifb.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("full nwrites", 64'(wr_b.size()), 64'd4);
    for (int k = 0; k < 4 && k < wr_b.size(); k++)
      chk($sformatf("full write%0d", k), 64'(wr_b[k]), 64'(exp[k]));
    chk("full done_pulses", 64'(done_b_n), 64'd1);
    chk("full err_full", 64'(err_full_b), 64'd1);
    chk("full count", 64'(count_b), 64'd4);

    // Reset one cycle after an accept drops everything.
    open_a("rst");
    drive_a(mk(3'd7, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0));
    drive_a(mk(3'd2, 5'd2, 5'd0, 5'd0, 32'd7, 1'b0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst imem_we", 64'(ifa.imem_we), 64'd0);
    chk("rst in_ready", 64'(ifa.in_ready), 64'd0);
    chk("rst addr/wdata", 64'({ifa.imem_addr, ifa.imem_wdata}), 64'd0);
    chk("rst busy/done/count", 64'({busy_a, done_a, count_a}), 64'd0);
    chk("rst errs", 64'({err_imm_a, err_kind_a, err_full_a}), 64'd0);
    chk("rst dut_b err_full", 64'(err_full_b), 64'd0);
    open_a("post_rst");
    exp.delete();
    ins = mk(3'd6, 5'd9, 5'd0, 5'd0, 32'hABCD_E000, 1'b1);
    model_enc(ins, w, bi, bk); exp.push_back({8'd0, w});
    drive_a(ins);
    close_a("post_rst", exp, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
